// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage of a 5-stage MIPS pipeline.
// The result is computed when the op is accepted and committed to HI/LO after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_md_stall,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_divZero;
    logic [31:0]    r_pendHi;
    logic [31:0]    r_pendLo;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;

    logic               w_isMdOp;
    logic signed [63:0] w_prodS;
    logic [63:0]        w_prodU;
    logic               w_signedDiv;
    logic               w_negA;
    logic               w_negB;
    logic [31:0]        w_magA;
    logic [31:0]        w_magB;
    logic [31:0]        w_dividend;
    logic [31:0]        w_divisor;
    logic [31:0]        w_divisorSafe;
    logic [31:0]        w_quoRaw;
    logic [31:0]        w_remRaw;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic               w_divZero;

    assign w_isMdOp = (i_md_op <= OP_DIVU);

    assign w_prodS = $signed(i_a) * $signed(i_b);
    assign w_prodU = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes through the same unsigned divider; signs are restored
    // afterwards so the quotient truncates toward zero and the remainder follows the dividend.
    // This also makes 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
    assign w_signedDiv   = (i_md_op == OP_DIV);
    assign w_negA        = i_a[31];
    assign w_negB        = i_b[31];
    assign w_magA        = w_negA ? (~i_a + 32'd1) : i_a;
    assign w_magB        = w_negB ? (~i_b + 32'd1) : i_b;
    assign w_dividend    = w_signedDiv ? w_magA : i_a;
    assign w_divisor     = w_signedDiv ? w_magB : i_b;
    assign w_divZero     = (i_b == 32'd0);
    assign w_divisorSafe = w_divZero ? 32'd1 : w_divisor;
    assign w_quoRaw      = w_dividend / w_divisorSafe;
    assign w_remRaw      = w_dividend % w_divisorSafe;
    assign w_quo = (w_signedDiv && (w_negA ^ w_negB)) ? (~w_quoRaw + 32'd1) : w_quoRaw;
    assign w_rem = (w_signedDiv && w_negA) ? (~w_remRaw + 32'd1) : w_remRaw;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_divZero <= 1'b0;
            r_pendHi  <= 32'd0;
            r_pendLo  <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        case (i_md_op)
                            OP_MULT: begin
                                r_pendHi  <= w_prodS[63:32];
                                r_pendLo  <= w_prodS[31:0];
                                r_divZero <= 1'b0;
                                r_cnt     <= CW'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= RUN;
                            end
                            OP_MULTU: begin
                                r_pendHi  <= w_prodU[63:32];
                                r_pendLo  <= w_prodU[31:0];
                                r_divZero <= 1'b0;
                                r_cnt     <= CW'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_pendHi  <= w_rem;
                                r_pendLo  <= w_quo;
                                r_divZero <= w_divZero;
                                r_cnt     <= CW'(DIV_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= RUN;
                            end
                            OP_MTHI: r_hi <= i_a;
                            OP_MTLO: r_lo <= i_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // A divide by zero still burns the full latency but leaves HI/LO alone.
                        if (!r_divZero) begin
                            r_hi <= r_pendHi;
                            r_lo <= r_pendLo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_md_stall = r_busy | (i_start & w_isMdOp);
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a behavioural HI/LO model checked every cycle, plus literal
// expectations for the hand-worked cases.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        tbStart;
    logic [2:0]  tbOp;
    logic [31:0] tbA;
    logic [31:0] tbB;
    logic        o_busy;
    logic        o_md_stall;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int vectors = 0;
    int miscompares = 0;
    bit chkEn = 0;

    bit          mBusy = 0;
    int          mLeft = 0;
    bit          mDivZero = 0;
    logic [31:0] mHi = 0;
    logic [31:0] mLo = 0;
    logic [31:0] mPendHi = 0;
    logic [31:0] mPendLo = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (tbStart),
        .i_md_op    (tbOp),
        .i_a        (tbA),
        .i_b        (tbB),
        .o_busy     (o_busy),
        .o_md_stall (o_md_stall),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Returns {hi, lo} straight from the arithmetic definitions using 64-bit integers.
    function automatic logic [63:0] mdResult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] uq;
        logic [63:0] ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        mdResult = 64'd0;
        case (op)
            3'd0: begin
                q = sx * sy;
                mdResult = q;
            end
            3'd1: mdResult = ux * uy;
            3'd2: if (y != 0) begin
                q = sx / sy;
                r = sx % sy;
                mdResult = {r[31:0], q[31:0]};
            end
            3'd3: if (y != 0) begin
                uq = ux / uy;
                ur = ux % uy;
                mdResult = {ur[31:0], uq[31:0]};
            end
            default: mdResult = 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mBusy = 0;
            mLeft = 0;
            mHi   = 0;
            mLo   = 0;
        end else if (mBusy) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mBusy = 0;
                if (!mDivZero) begin
                    mHi = mPendHi;
                    mLo = mPendLo;
                end
            end
        end else if (tbStart) begin
            if (tbOp <= 3'd3) begin
                {mPendHi, mPendLo} = mdResult(tbOp, tbA, tbB);
                mDivZero = (tbOp >= 3'd2) && (tbB == 32'd0);
                mBusy    = 1;
                mLeft    = (tbOp <= 3'd1) ? 5 : 10;
            end else if (tbOp == 3'd4) begin
                mHi = tbA;
            end else if (tbOp == 3'd5) begin
                mLo = tbA;
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            check32("model busy", {31'd0, o_busy}, {31'd0, mBusy});
            check32("model md_stall", {31'd0, o_md_stall},
                    {31'd0, mBusy | (tbStart & (tbOp <= 3'd3))});
            check32("model hi", o_hi, mHi);
            check32("model lo", o_lo, mLo);
        end
    end

    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        tbStart = s;
        tbOp    = op;
        tbA     = x;
        tbB     = y;
    endtask

    task automatic checkOutput(input string name, input logic busyExp, input logic [31:0] hiExp, input logic [31:0] loExp);
        check32({name, " busy"}, {31'd0, o_busy}, {31'd0, busyExp});
        check32({name, " hi"}, o_hi, hiExp);
        check32({name, " lo"}, o_lo, loExp);
    endtask

    // Issues one md op for a single cycle and measures how long busy stays high.
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int expCycles);
        int cycles;
        applyStimulus(1'b1, op, x, y);
        @(negedge clk);
        check32({name, " issue stall"}, {31'd0, o_md_stall}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        cycles = 0;
        while (o_busy && cycles < 100) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        check32({name, " busy cycles"}, cycles, expCycles);
    endtask

    initial begin
        int cycles;
        reset = 1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        chkEn = 1;
        @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'd0, 32'd0);
        check32("reset md_stall", {31'd0, o_md_stall}, 32'd0);
        reset = 0;

        runOp("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5);
        checkOutput("mult", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        checkOutput("multu", 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

        runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
        checkOutput("div", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        applyStimulus(1'b1, 3'd4, 32'h11, 32'd0);
        @(posedge clk);
        #1;
        check32("mthi busy", {31'd0, o_busy}, 32'd0);
        applyStimulus(1'b1, 3'd5, 32'h22, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("mthi/mtlo", 1'b0, 32'h11, 32'h22);

        runOp("divu by zero", 3'd3, 32'd7, 32'd0, 10);
        checkOutput("divu by zero", 1'b0, 32'h11, 32'h22);

        runOp("div overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        checkOutput("div overflow", 1'b0, 32'h0, 32'h8000_0000);

        runOp("div neg divisor", 3'd2, 32'd7, 32'hFFFF_FFFE, 10);
        checkOutput("div neg divisor", 1'b0, 32'd1, 32'hFFFF_FFFD);

        applyStimulus(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        checkOutput("reserved op", 1'b0, 32'd1, 32'hFFFF_FFFD);

        applyStimulus(1'b1, 3'd2, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 3'd0, 32'd5, 32'd5);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 32'd9, 32'd9);
        cycles = 0;
        while (o_busy && cycles < 100) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        check32("capture busy cycles", cycles, 6);
        checkOutput("capture", 1'b0, 32'd2, 32'd14);

        applyStimulus(1'b1, 3'd2, 32'd50, 32'd3);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        checkOutput("mid-op reset", 1'b0, 32'd0, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("after reset idle", 1'b0, 32'd0, 32'd0);

        runOp("multu small", 3'd1, 32'd6, 32'd7, 5);
        checkOutput("multu small", 1'b0, 32'd0, 32'd42);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
